alu_power_ctrl: RTL and testbench

Per-domain power sequencer that generates the `iso_ctrl` / `psw_ctrl` buses consumed by the low-power ALU. It sits directly upstream of the ALU.

- Each of the ALU's four power domains gets an independent FSM.
- Each FSM orders isolation, switch-off, switch-on and settle against power-switch acknowledges.
- Power-down only begins when the ALU reports no operation in flight.

---
 rtl/alu_pwr_pkg.sv | 25 ++
 rtl/alu_pwr_dom_fsm.sv | 121 ++++++++++++
 rtl/alu_power_ctrl.sv | 43 ++++
 tb/tb_alu_power_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pwr_pkg.sv
// Shared types and default constants for the ALU power-domain sequencer.
package alu_pwr_pkg;

  typedef enum logic [2:0] {
    StOn      = 3'd0,
    StIso     = 3'd1,
    StOffWait = 3'd2,
    StOff     = 3'd3,
    StPwrUp   = 3'd4,
    StSettle  = 3'd5
  } pwr_state_e;

  localparam int unsigned DefNumDom     = 4;
  localparam int unsigned DefIsoSetup   = 2;
  localparam int unsigned DefSettle     = 4;
  localparam int unsigned DefAckTimeout = 16;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/alu_pwr_dom_fsm.sv
// One power domain: isolation/switch sequencing FSM, dwell counter and sticky
// acknowledge-timeout flag.
module alu_pwr_dom_fsm
  import alu_pwr_pkg::*;
#(
  parameter int unsigned ISO_SETUP   = DefIsoSetup,
  parameter int unsigned SETTLE      = DefSettle,
  parameter int unsigned ACK_TIMEOUT = DefAckTimeout
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pd_req,
  input  logic alu_busy,
  input  logic psw_ack,
  input  logic err_clr,
  output logic iso,
  output logic psw,
  output logic dom_on,
  output logic err
);

  localparam int unsigned CntW = $clog2(max3(ISO_SETUP, SETTLE, ACK_TIMEOUT)) + 1;

  // The count holds edges already spent in the state, so "N cycles in the
  // state" is reached when the count equals N-1 at the deciding edge.
  localparam logic [CntW-1:0] IsoLim    = CntW'(ISO_SETUP - 1);
  localparam logic [CntW-1:0] SettleLim = CntW'(SETTLE - 1);
  localparam logic [CntW-1:0] AckLim    = CntW'(ACK_TIMEOUT - 1);

  pwr_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            iso_q, iso_d;
  logic            psw_q, psw_d;
  logic            dom_on_q, dom_on_d;
  logic            err_q, err_d;
  logic            timeout;

  always_comb begin
    state_d = state_q;
    timeout = 1'b0;
    unique case (state_q)
      StOn: begin
        if (pd_req && !alu_busy) state_d = StIso;
      end
      StIso: begin
        if (!pd_req) begin
          state_d = StOn;
        end else if (cnt_q >= IsoLim) begin
          state_d = StOffWait;
        end
      end
      StOffWait: begin
        if (!psw_ack) begin
          state_d = StOff;
        end else if (cnt_q >= AckLim) begin
          state_d = StOff;
          timeout = 1'b1;
        end
      end
      StOff: begin
        if (!pd_req) state_d = StPwrUp;
      end
      StPwrUp: begin
        if (psw_ack) begin
          state_d = StSettle;
        end else if (cnt_q >= AckLim) begin
          state_d = StSettle;
          timeout = 1'b1;
        end
      end
      StSettle: begin
        if (cnt_q >= SettleLim) state_d = StOn;
      end
      default: state_d = StOn;
    endcase
  end

  always_comb begin
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end

    // Outputs are decoded from the next state so they leave a flop directly.
    iso_d    = (state_d != StOn);
    psw_d    = (state_d != StOffWait) && (state_d != StOff);
    dom_on_d = (state_d == StOn);

    // A timeout in the same cycle as a clear keeps the flag set.
    err_d = err_q;
    if (err_clr) err_d = 1'b0;
    if (timeout) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StOn;
      cnt_q    <= '0;
      iso_q    <= 1'b0;
      psw_q    <= 1'b1;
      dom_on_q <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      iso_q    <= iso_d;
      psw_q    <= psw_d;
      dom_on_q <= dom_on_d;
      err_q    <= err_d;
    end
  end

  assign iso    = iso_q;
  assign psw    = psw_q;
  assign dom_on = dom_on_q;
  assign err    = err_q;

endmodule

// File: rtl/alu_power_ctrl.sv
// Per-domain power sequencer driving the ALU isolation and power-switch buses.
module alu_power_ctrl
  import alu_pwr_pkg::*;
#(
  parameter int unsigned NUM_DOM     = DefNumDom,
  parameter int unsigned ISO_SETUP   = DefIsoSetup,
  parameter int unsigned SETTLE      = DefSettle,
  parameter int unsigned ACK_TIMEOUT = DefAckTimeout
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_DOM-1:0] pd_req,
  input  logic               alu_busy,
  input  logic [NUM_DOM-1:0] psw_ack,
  input  logic               err_clr,
  output logic [NUM_DOM-1:0] iso_ctrl,
  output logic [NUM_DOM-1:0] psw_ctrl,
  output logic [NUM_DOM-1:0] dom_on,
  output logic [NUM_DOM-1:0] err
);

  // alu_busy and err_clr are shared by every domain; each FSM only consults
  // alu_busy when leaving ON, so several domains may start together.
  for (genvar d = 0; d < NUM_DOM; d++) begin : g_dom
    alu_pwr_dom_fsm #(
      .ISO_SETUP   (ISO_SETUP),
      .SETTLE      (SETTLE),
      .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_dom (
      .clk      (clk),
      .rst_n    (rst_n),
      .pd_req   (pd_req[d]),
      .alu_busy (alu_busy),
      .psw_ack  (psw_ack[d]),
      .err_clr  (err_clr),
      .iso      (iso_ctrl[d]),
      .psw      (psw_ctrl[d]),
      .dom_on   (dom_on[d]),
      .err      (err[d])
    );
  end

endmodule

// File: tb/tb_alu_power_ctrl.sv
// Self-checking bench for alu_power_ctrl: directed scenarios plus randomized
// traffic against a cycle-stepped behavioural model of the domain sequencing.
module tb_alu_power_ctrl;

  localparam int ND   = 4;
  localparam int ISU  = 2;
  localparam int STL  = 4;
  localparam int ATO  = 16;

  // Model phases, named after what the domain is doing.
  localparam int PH_ON       = 0;
  localparam int PH_CLAMPING = 1;
  localparam int PH_DRAINING = 2;
  localparam int PH_DARK     = 3;
  localparam int PH_RAMPING  = 4;
  localparam int PH_SETTLING = 5;

  logic          clk;
  logic          rst_n;
  logic [ND-1:0] pd_req;
  logic          alu_busy;
  logic [ND-1:0] psw_ack;
  logic          err_clr;
  logic [ND-1:0] iso_ctrl;
  logic [ND-1:0] psw_ctrl;
  logic [ND-1:0] dom_on;
  logic [ND-1:0] err;

  int total;
  int bad;

  int phase [ND];
  int dwell [ND];
  bit m_err [ND];

  alu_power_ctrl #(
    .NUM_DOM     (ND),
    .ISO_SETUP   (ISU),
    .SETTLE      (STL),
    .ACK_TIMEOUT (ATO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pd_req   (pd_req),
    .alu_busy (alu_busy),
    .psw_ack  (psw_ack),
    .err_clr  (err_clr),
    .iso_ctrl (iso_ctrl),
    .psw_ctrl (psw_ctrl),
    .dom_on   (dom_on),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  function automatic void model_reset();
    for (int d = 0; d < ND; d++) begin
      phase[d] = PH_ON;
      dwell[d] = 0;
      m_err[d] = 1'b0;
    end
  endfunction

  // Advance the model by one clock edge using the inputs presented now.
  function automatic void model_step();
    for (int d = 0; d < ND; d++) begin
      int  elapsed;
      int  nxt;
      bit  to;
      elapsed = dwell[d] + 1;
      nxt     = phase[d];
      to      = 1'b0;
      case (phase[d])
        PH_ON:       if (pd_req[d] && !alu_busy) nxt = PH_CLAMPING;
        PH_CLAMPING: if (!pd_req[d]) nxt = PH_ON;
                     else if (elapsed >= ISU) nxt = PH_DRAINING;
        PH_DRAINING: if (!psw_ack[d]) nxt = PH_DARK;
                     else if (elapsed >= ATO) begin nxt = PH_DARK; to = 1'b1; end
        PH_DARK:     if (!pd_req[d]) nxt = PH_RAMPING;
        PH_RAMPING:  if (psw_ack[d]) nxt = PH_SETTLING;
                     else if (elapsed >= ATO) begin nxt = PH_SETTLING; to = 1'b1; end
        default:     if (elapsed >= STL) nxt = PH_ON;
      endcase
      if (err_clr) m_err[d] = 1'b0;
      if (to) m_err[d] = 1'b1;
      dwell[d] = (nxt != phase[d]) ? 0 : elapsed;
      phase[d] = nxt;
    end
  endfunction

  function automatic logic [ND-1:0] exp_iso();
    logic [ND-1:0] v;
    for (int d = 0; d < ND; d++) v[d] = (phase[d] != PH_ON);
    return v;
  endfunction

  function automatic logic [ND-1:0] exp_psw();
    logic [ND-1:0] v;
    for (int d = 0; d < ND; d++) v[d] = !(phase[d] == PH_DRAINING || phase[d] == PH_DARK);
    return v;
  endfunction

  function automatic logic [ND-1:0] exp_on();
    logic [ND-1:0] v;
    for (int d = 0; d < ND; d++) v[d] = (phase[d] == PH_ON);
    return v;
  endfunction

  function automatic logic [ND-1:0] exp_err();
    logic [ND-1:0] v;
    for (int d = 0; d < ND; d++) v[d] = m_err[d];
    return v;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic sync_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    pd_req = '0; alu_busy = 1'b0; psw_ack = '1; err_clr = 1'b0;
    sync_reset();
    total++;
    if (iso_ctrl !== 4'h0) begin bad++; $display("FAIL reset_iso: got %h want 0", iso_ctrl); end
    total++;
    if (psw_ctrl !== 4'hF) begin bad++; $display("FAIL reset_psw: got %h want f", psw_ctrl); end
    total++;
    if (dom_on !== 4'hF) begin bad++; $display("FAIL reset_dom_on: got %h want f", dom_on); end
    total++;
    if (err !== 4'h0) begin bad++; $display("FAIL reset_err: got %h want 0", err); end
  endtask

  task automatic test_power_down();
    pd_req = 4'h1;
    tick();
    total++;
    if (iso_ctrl !== 4'h1 || psw_ctrl !== 4'hF) begin
      bad++; $display("FAIL pd_iso_rise: got iso=%h psw=%h want iso=1 psw=f", iso_ctrl, psw_ctrl);
    end
    tick();
    total++;
    if (psw_ctrl !== 4'hF) begin bad++; $display("FAIL pd_psw_early: got %h want f", psw_ctrl); end
    tick();
    total++;
    if (psw_ctrl !== 4'hE) begin bad++; $display("FAIL pd_psw_fall: got %h want e", psw_ctrl); end
    for (int i = 0; i < 3; i++) begin
      if (i == 2) psw_ack[0] = 1'b0;
      tick();
      total++;
      if (dom_on !== 4'hE || iso_ctrl !== exp_iso() || psw_ctrl !== exp_psw()) begin
        bad++;
        $display("FAIL pd_hold[%0d]: got on=%h iso=%h psw=%h want on=e iso=%h psw=%h",
                 i, dom_on, iso_ctrl, psw_ctrl, exp_iso(), exp_psw());
      end
    end
  endtask

  task automatic test_busy_abort();
    pd_req = 4'h3; alu_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (iso_ctrl !== 4'h1 || dom_on !== 4'hE || psw_ctrl !== 4'hE) begin
        bad++;
        $display("FAIL busy_gate[%0d]: got iso=%h on=%h psw=%h want iso=1 on=e psw=e",
                 i, iso_ctrl, dom_on, psw_ctrl);
      end
    end
    alu_busy = 1'b0;
    tick();
    total++;
    if (iso_ctrl !== 4'h3 || dom_on !== 4'hC) begin
      bad++; $display("FAIL busy_release: got iso=%h on=%h want iso=3 on=c", iso_ctrl, dom_on);
    end
    pd_req = 4'h1;
    tick();
    total++;
    if (iso_ctrl !== 4'h1 || dom_on !== 4'hE || psw_ctrl !== 4'hE) begin
      bad++;
      $display("FAIL abort: got iso=%h on=%h psw=%h want iso=1 on=e psw=e",
               iso_ctrl, dom_on, psw_ctrl);
    end
  endtask

  task automatic test_power_up();
    pd_req = 4'h5;
    tick(); tick(); tick();
    total++;
    if (psw_ctrl[2] !== 1'b0) begin bad++; $display("FAIL pu_prep: got %b want 0", psw_ctrl[2]); end
    psw_ack[2] = 1'b0;
    tick();
    pd_req = 4'h1;
    tick();
    total++;
    if (psw_ctrl[2] !== 1'b1) begin bad++; $display("FAIL pu_psw_rise: got %b want 1", psw_ctrl[2]); end
    tick();
    psw_ack[2] = 1'b1;
    tick();
    for (int i = 1; i <= STL; i++) begin
      tick();
      total++;
      if (i < STL && (iso_ctrl[2] !== 1'b1 || dom_on[2] !== 1'b0)) begin
        bad++;
        $display("FAIL pu_settle[%0d]: got iso=%b on=%b want iso=1 on=0", i, iso_ctrl[2], dom_on[2]);
      end else if (i == STL && (iso_ctrl[2] !== 1'b0 || dom_on[2] !== 1'b1)) begin
        bad++;
        $display("FAIL pu_done: got iso=%b on=%b want iso=0 on=1", iso_ctrl[2], dom_on[2]);
      end
    end
  endtask

  task automatic test_timeout();
    psw_ack[3] = 1'b1;
    pd_req = 4'h9;
    tick(); tick(); tick();
    for (int i = 1; i <= ATO; i++) begin
      tick();
      if (i == ATO - 1) begin
        total++;
        if (err[3] !== 1'b0) begin bad++; $display("FAIL to_early: got %b want 0", err[3]); end
      end
    end
    total++;
    if (err !== 4'h8) begin bad++; $display("FAIL to_set: got %h want 8", err); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    total++;
    if (err !== 4'h0) begin bad++; $display("FAIL to_clear: got %h want 0", err); end
    // Domain 3 sits in OFF, so dropping its request must restart the switch.
    pd_req = 4'h1;
    tick();
    total++;
    if (psw_ctrl[3] !== 1'b1) begin bad++; $display("FAIL to_off: got %b want 1", psw_ctrl[3]); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int d = 0; d < ND; d++) begin
        if ($urandom_range(0, 7) == 0) pd_req[d] = ~pd_req[d];
        if ($urandom_range(0, 3) != 0) psw_ack[d] = psw_ctrl[d];
      end
      alu_busy = 1'($urandom_range(0, 1));
      err_clr  = ($urandom_range(0, 15) == 0);
      tick();
      total++;
      if (iso_ctrl !== exp_iso() || psw_ctrl !== exp_psw() || dom_on !== exp_on()
          || err !== exp_err()) begin
        bad++;
        $display("FAIL rand[%0d]: got iso=%h psw=%h on=%h err=%h want iso=%h psw=%h on=%h err=%h",
                 c, iso_ctrl, psw_ctrl, dom_on, err, exp_iso(), exp_psw(), exp_on(), exp_err());
      end
    end
    err_clr = 1'b0;
  endtask

  task automatic test_async_reset();
    pd_req = '0; alu_busy = 1'b0; psw_ack = '1; err_clr = 1'b0;
    sync_reset();
    pd_req = 4'h1;
    tick(); tick(); tick();
    total++;
    if (psw_ctrl !== 4'hE || iso_ctrl !== 4'h1) begin
      bad++; $display("FAIL ar_prep: got psw=%h iso=%h want psw=e iso=1", psw_ctrl, iso_ctrl);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (iso_ctrl !== 4'h0 || psw_ctrl !== 4'hF || dom_on !== 4'hF || err !== 4'h0) begin
      bad++;
      $display("FAIL async_reset: got iso=%h psw=%h on=%h err=%h want iso=0 psw=f on=f err=0",
               iso_ctrl, psw_ctrl, dom_on, err);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b1;
    model_reset();
    test_reset();
    test_power_down();
    test_busy_abort();
    test_power_up();
    test_timeout();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
